// File: rtl/ldpc_frame_sequencer.sv
// Load/read sequencer for LDPC_Decoder: scatters an LLR stream into the K*K PE
// memories, waits for the f_id toggle, then gathers hard decisions row by row.
module ldpc_frame_sequencer #(
   parameter int L             = 32,
   parameter int K             = 6,
   parameter int ADDR_WIDTH    = 5,
   parameter int MESSAGE_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [MESSAGE_WIDTH-1:0] in_data,
   output logic                     in_ready,
   output logic                     en,
   output logic [K*K-1:0]           pe_select,
   output logic [ADDR_WIDTH-1:0]    load_add_in,
   output logic [MESSAGE_WIDTH-1:0] int_in,
   input  logic                     f_id,
   output logic [ADDR_WIDTH-1:0]    read_add_in,
   output logic [K-1:0]             column_select,
   input  logic [K-1:0]             dec_col,
   output logic                     out_valid,
   output logic [K*K-1:0]           out_data,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam int PE_W = $clog2(K*K);
   localparam int C_W  = $clog2(K+1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, READ, EMIT} state_t;
   state_t state, state_nxt;

   logic                     fid_ref, pending;
   logic [ADDR_WIDTH-1:0]    row, r;
   logic [PE_W-1:0]          pe;
   logic                     wr_valid;
   logic [ADDR_WIDTH-1:0]    wr_row;
   logic [PE_W-1:0]          wr_pe;
   logic [MESSAGE_WIDTH-1:0] wr_data;
   logic [C_W-1:0]           c, cap_col;
   logic                     cap_valid;
   logic [K*K-1:0]           word;

   logic hs, last_sample, toggled, strobe, col_done, last_row;

   assign hs          = in_valid && (state == LOAD);
   assign last_sample = (pe == PE_W'(K*K-1)) && (row == ADDR_WIDTH'(L-1));
   assign toggled     = (f_id != fid_ref);
   // c == K marks "all columns strobed"; the last capture is still in flight
   assign strobe      = (state == READ) && (c < C_W'(K));
   assign col_done    = cap_valid && (cap_col == C_W'(K-1));
   assign last_row    = (r == ADDR_WIDTH'(L-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: state_nxt = LOAD;
         LOAD: if (hs && last_sample) state_nxt = WAIT;
         WAIT: if (toggled || pending) state_nxt = READ;
         READ: if (col_done) state_nxt = EMIT;
         EMIT: if (out_ready) state_nxt = last_row ? IDLE : READ;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fid_ref   <= 1'b0;
         pending   <= 1'b0;
         row       <= '0;
         pe        <= '0;
         wr_valid  <= 1'b0;
         wr_row    <= '0;
         wr_pe     <= '0;
         wr_data   <= '0;
         r         <= '0;
         c         <= '0;
         cap_valid <= 1'b0;
         cap_col   <= '0;
         word      <= '0;
      end else begin
         if (state == IDLE) begin
            fid_ref <= f_id;
            pending <= 1'b0;
            row     <= '0;
            pe      <= '0;
            r       <= '0;
            c       <= '0;
         end
         if (state == LOAD && toggled) pending <= 1'b1;

         wr_valid <= hs;
         if (hs) begin
            wr_row  <= row;
            wr_pe   <= pe;
            wr_data <= in_data;
            if (row == ADDR_WIDTH'(L-1)) begin
               row <= '0;
               pe  <= pe + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end

         cap_valid <= strobe;
         cap_col   <= c;
         if (strobe) c <= c + 1'b1;
         if (cap_valid) word[int'(cap_col)*K +: K] <= dec_col;

         if (state == EMIT && out_ready) begin
            c <= '0;
            r <= last_row ? '0 : r + 1'b1;
         end
      end
   end

   always_comb begin
      in_ready      = (state == LOAD);
      en            = (state != IDLE);
      pe_select     = '0;
      load_add_in   = '0;
      int_in        = '0;
      read_add_in   = '0;
      column_select = '0;
      // the final LLR write lands in the first WAIT cycle, so it is keyed off wr_valid
      if (wr_valid) begin
         pe_select   = {{(K*K-1){1'b0}}, 1'b1} << wr_pe;
         load_add_in = wr_row;
         int_in      = wr_data;
      end
      if (strobe) begin
         read_add_in   = r;
         column_select = {{(K-1){1'b0}}, 1'b1} << c;
      end
      out_valid = (state == EMIT);
      out_last  = (state == EMIT) && last_row;
      out_data  = word;
   end

endmodule

// File: tb/tb_ldpc_frame_sequencer.sv
// Scoreboard bench for ldpc_frame_sequencer: PE writes and output words are
// queued by the stimulus and checked by independent negedge monitors.
module tb_ldpc_frame_sequencer;

   localparam int L  = 32;
   localparam int K  = 6;
   localparam int AW = 5;
   localparam int MW = 5;
   localparam int N  = L*K*K;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [MW-1:0] in_data = '0;
   logic          in_ready, en;
   logic [K*K-1:0] pe_select;
   logic [AW-1:0] load_add_in;
   logic [MW-1:0] int_in;
   logic          f_id = 1'b0;
   logic [AW-1:0] read_add_in;
   logic [K-1:0]  column_select;
   logic [K-1:0]  dec_col = '0;
   logic          out_valid;
   logic [K*K-1:0] out_data;
   logic          out_last;
   logic          out_ready = 1'b1;

   int tests = 0;
   int fails = 0;
   int words_seen = 0;

   typedef struct {
      logic [K*K-1:0] sel;
      logic [AW-1:0]  addr;
      logic [MW-1:0]  data;
   } wr_t;
   typedef struct {
      logic [K*K-1:0] data;
      logic           last;
   } wd_t;

   wr_t wr_q[$];
   wd_t wd_q[$];
   wr_t mon_wr;
   wd_t mon_wd;

   ldpc_frame_sequencer #(.L(L), .K(K), .ADDR_WIDTH(AW), .MESSAGE_WIDTH(MW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .en(en), .pe_select(pe_select), .load_add_in(load_add_in), .int_in(int_in),
      .f_id(f_id), .read_add_in(read_add_in), .column_select(column_select),
      .dec_col(dec_col), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // decoder model: column c of row r returns {r[2:0], c[2:0]} one cycle later
   always @(posedge clk) begin
      dec_col <= '0;
      for (int i = 0; i < K; i++)
         if (column_select[i]) dec_col <= {read_add_in[2:0], 3'(i)};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [K*K-1:0] exp_word(input int r);
      logic [K*K-1:0] w;
      logic [2:0] rr;
      rr = 3'(r);
      w = '0;
      for (int c = 0; c < K; c++) w[c*K +: K] = {rr, 3'(c)};
      return w;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (pe_select != '0) begin
            if (wr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL pe_write_unexpected: got pe_select=%0h expected none", pe_select);
            end else begin
               mon_wr = wr_q.pop_front();
               check("pe_select", 64'(pe_select), 64'(mon_wr.sel));
               check("load_add_in", 64'(load_add_in), 64'(mon_wr.addr));
               check("int_in", 64'(int_in), 64'(mon_wr.data));
            end
         end
         if (out_valid && out_ready) begin
            words_seen++;
            if (wd_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL word_unexpected: got out_data=%0h expected none", out_data);
            end else begin
               mon_wd = wd_q.pop_front();
               check("out_data", 64'(out_data), 64'(mon_wd.data));
               check("out_last", 64'(out_last), 64'(mon_wd.last));
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, " in_ready"}, 64'(in_ready), 0);
      check({tag, " en"}, 64'(en), 0);
      check({tag, " pe_select"}, 64'(pe_select), 0);
      check({tag, " load_add_in"}, 64'(load_add_in), 0);
      check({tag, " int_in"}, 64'(int_in), 0);
      check({tag, " column_select"}, 64'(column_select), 0);
      check({tag, " read_add_in"}, 64'(read_add_in), 0);
      check({tag, " out_valid"}, 64'(out_valid), 0);
      check({tag, " out_last"}, 64'(out_last), 0);
   endtask

   task automatic load_frame(input int ns, input bit gaps, input int tog, input int mode);
      int  n = 0;
      int  cyc = 0;
      wr_t e;
      while (n < ns && cyc < ns*4 + 100) begin
         @(posedge clk); #1; cyc++;
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = MW'(mode == 0 ? n % 32 : (n*7 + 3) % 32);
         if (in_valid && in_ready) begin
            e.sel = '0;
            e.sel[n/L] = 1'b1;
            e.addr = AW'(n % L);
            e.data = in_data;
            wr_q.push_back(e);
            n++;
            if (n == tog) f_id = ~f_id;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (n < ns) begin
         tests++; fails++;
         $display("FAIL load_timeout: got %0d samples expected %0d", n, ns);
      end
   endtask

   task automatic push_frame_words();
      wd_t w;
      for (int r = 0; r < L; r++) begin
         w.data = exp_word(r);
         w.last = (r == L-1);
         wd_q.push_back(w);
      end
   endtask

   task automatic drain(input int hold_word);
      int cyc = 0;
      int start = words_seen;
      bit held = 1'b0;
      out_ready = 1'b1;
      while (words_seen < start + L && cyc < 3000) begin
         @(posedge clk); #1; cyc++;
         if (!held && out_valid && (words_seen - start) == hold_word) begin
            held = 1'b1;
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
               @(posedge clk); #1; cyc++;
               check("hold out_data", 64'(out_data), 64'(exp_word(hold_word)));
               check("hold column_select", 64'(column_select), 0);
               check("hold out_valid", 64'(out_valid), 1);
            end
            out_ready = 1'b1;
         end
      end
      check("words drained", 64'(words_seen - start), 64'(L));
      check("word queue empty", 64'(wd_q.size()), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // frame 1: continuous stream, toggle in WAIT, backpressure on word 5
      load_frame(N, 1'b0, -1, 0);
      check("in_ready after full frame", 64'(in_ready), 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("wait column_select", 64'(column_select), 0);
      end
      check("wait en", 64'(en), 1);
      check("write queue after frame 1", 64'(wr_q.size()), 0);
      push_frame_words();
      f_id = ~f_id;
      drain(5);

      // frame 2: random gaps, f_id toggles at sample 500
      load_frame(N, 1'b1, 500, 1);
      check("pending wait column_select", 64'(column_select), 0);
      check("in_ready after gapped frame", 64'(in_ready), 0);
      push_frame_words();
      @(posedge clk); #1;
      check("pending read column_select", 64'(column_select), 1);
      check("pending read read_add_in", 64'(read_add_in), 0);
      drain(-1);
      check("write queue after frame 2", 64'(wr_q.size()), 0);

      // frame 3: reset mid-load, then restart at pe 0 row 0
      load_frame(700, 1'b0, -1, 0);
      rst = 1'b1;
      #1;
      check_all_zero("midframe reset");
      wr_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      load_frame(40, 1'b0, -1, 0);
      @(posedge clk); #1;
      @(negedge clk); #1;
      check("write queue after restart", 64'(wr_q.size()), 0);
      check("in_ready during restart load", 64'(in_ready), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
